// File: rtl/control_sequencer.sv
// control_sequencer: hardwired Moore control unit for the single-bus DataPath.
// Sequences instruction fetch (T0-T2) and the opcode-specific execute steps (T3-T7).
module control_sequencer (
   input  logic        clock,
   input  logic        clear,
   input  logic [31:0] IR,
   input  logic        CON,
   output logic        PCout,
   output logic        PCin,
   output logic        IncPC,
   output logic        MARin,
   output logic        Read,
   output logic        Write,
   output logic        MD_read,
   output logic        MDRin,
   output logic        MDRout,
   output logic        IRin,
   output logic        Yin,
   output logic        Zlowin,
   output logic        Zlowout,
   output logic        Gra,
   output logic        Grb,
   output logic        Grc,
   output logic        Rin,
   output logic        Rout,
   output logic        BAout,
   output logic        Csignout,
   output logic        CONin,
   output logic        ADD,
   output logic        SUB,
   output logic        AND,
   output logic        OR,
   output logic        Run
);

   localparam logic [4:0] OP_LD   = 5'b00000;
   localparam logic [4:0] OP_LDI  = 5'b00001;
   localparam logic [4:0] OP_ST   = 5'b00010;
   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_AND  = 5'b00101;
   localparam logic [4:0] OP_OR   = 5'b00110;
   localparam logic [4:0] OP_ADDI = 5'b01100;
   localparam logic [4:0] OP_ANDI = 5'b01101;
   localparam logic [4:0] OP_ORI  = 5'b01110;
   localparam logic [4:0] OP_BR   = 5'b10010;
   localparam logic [4:0] OP_JR   = 5'b10100;
   localparam logic [4:0] OP_HALT = 5'b11011;

   typedef enum logic [3:0] {
      S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
   } state_t;

   typedef enum logic [3:0] {
      C_NOP, C_LDI, C_LD, C_ST, C_RALU, C_IALU, C_BR, C_JR, C_HALT
   } iclass_t;

   state_t     state_q, state_d;
   logic [4:0] op_q, op_d;
   logic [4:0] op_s;
   iclass_t    cls_s;
   logic [3:0] alu_s;
   logic       unused_ir_s;

   // Only the opcode field of IR matters to the sequencer.
   assign unused_ir_s = ^IR[26:0];
   assign op_s = (state_q == S_T3) ? IR[31:27] : op_q;

   // Opcode decode into an instruction class and a one-hot {OR,AND,SUB,ADD} select.
   always_comb begin
      cls_s = C_NOP;
      alu_s = 4'b0001;
      case (op_s)
         OP_LD:   cls_s = C_LD;
         OP_LDI:  cls_s = C_LDI;
         OP_ST:   cls_s = C_ST;
         OP_ADD:  cls_s = C_RALU;
         OP_SUB:  begin cls_s = C_RALU; alu_s = 4'b0010; end
         OP_AND:  begin cls_s = C_RALU; alu_s = 4'b0100; end
         OP_OR:   begin cls_s = C_RALU; alu_s = 4'b1000; end
         OP_ADDI: cls_s = C_IALU;
         OP_ANDI: begin cls_s = C_IALU; alu_s = 4'b0100; end
         OP_ORI:  begin cls_s = C_IALU; alu_s = 4'b1000; end
         OP_BR:   cls_s = C_BR;
         OP_JR:   cls_s = C_JR;
         OP_HALT: cls_s = C_HALT;
         default: cls_s = C_NOP;
      endcase
   end

   // State register and opcode latch; clear aborts any instruction at once.
   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         state_q <= S_RESET;
         op_q    <= 5'b00000;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
      end
   end

   // Next-state and Moore output decode.
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      PCout    = 1'b0; PCin    = 1'b0; IncPC  = 1'b0; MARin   = 1'b0;
      Read     = 1'b0; Write   = 1'b0; MD_read = 1'b0; MDRin  = 1'b0;
      MDRout   = 1'b0; IRin    = 1'b0; Yin    = 1'b0; Zlowin  = 1'b0;
      Zlowout  = 1'b0; Gra     = 1'b0; Grb    = 1'b0; Grc     = 1'b0;
      Rin      = 1'b0; Rout    = 1'b0; BAout  = 1'b0; Csignout = 1'b0;
      CONin    = 1'b0; ADD     = 1'b0; SUB    = 1'b0; AND     = 1'b0;
      OR       = 1'b0; Run     = 1'b0;
      case (state_q)
         S_RESET: state_d = S_T0;
         S_T0: begin
            Run = 1'b1; PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zlowin = 1'b1;
            state_d = S_T1;
         end
         S_T1: begin
            Run = 1'b1; Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MD_read = 1'b1; MDRin = 1'b1;
            state_d = S_T2;
         end
         S_T2: begin
            Run = 1'b1; MDRout = 1'b1; IRin = 1'b1;
            state_d = S_T3;
         end
         S_T3: begin
            Run  = 1'b1;
            op_d = IR[31:27];
            case (cls_s)
               C_LD, C_LDI, C_ST: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; state_d = S_T4; end
               C_RALU, C_IALU:    begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; state_d = S_T4; end
               C_BR:              begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; state_d = S_T4; end
               C_JR:              begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; state_d = S_T0; end
               C_HALT:            state_d = S_HALT;
               default:           state_d = S_T0;
            endcase
         end
         S_T4: begin
            Run = 1'b1;
            state_d = S_T5;
            case (cls_s)
               C_LD, C_LDI, C_ST: begin Csignout = 1'b1; ADD = 1'b1; Zlowin = 1'b1; end
               C_RALU: begin Grc = 1'b1; Rout = 1'b1; Zlowin = 1'b1; {OR, AND, SUB, ADD} = alu_s; end
               C_IALU: begin Csignout = 1'b1; Zlowin = 1'b1; {OR, AND, SUB, ADD} = alu_s; end
               C_BR:   begin PCout = 1'b1; Yin = 1'b1; end
               default: state_d = S_T0;
            endcase
         end
         S_T5: begin
            Run = 1'b1;
            state_d = S_T0;
            case (cls_s)
               C_LD, C_ST:            begin Zlowout = 1'b1; MARin = 1'b1; state_d = S_T6; end
               C_LDI, C_RALU, C_IALU: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
               C_BR:                  begin Csignout = 1'b1; ADD = 1'b1; Zlowin = 1'b1; state_d = S_T6; end
               default:               state_d = S_T0;
            endcase
         end
         S_T6: begin
            Run = 1'b1;
            state_d = S_T0;
            case (cls_s)
               C_LD: begin Read = 1'b1; MD_read = 1'b1; MDRin = 1'b1; state_d = S_T7; end
               C_ST: begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; state_d = S_T7; end
               C_BR: begin Zlowout = CON; PCin = CON; end
               default: state_d = S_T0;
            endcase
         end
         S_T7: begin
            Run = 1'b1;
            state_d = S_T0;
            case (cls_s)
               C_LD:    begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
               C_ST:    Write = 1'b1;
               default: state_d = S_T0;
            endcase
         end
         S_HALT:  state_d = S_HALT;
         default: state_d = S_RESET;
      endcase
   end

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized self-checking bench for control_sequencer, comparing every cycle
// against a per-instruction micro-step list built from the instruction set.
module tb_control_sequencer;

   localparam logic [4:0] OP_LD = 5'b00000, OP_LDI = 5'b00001, OP_ST = 5'b00010;
   localparam logic [4:0] OP_ADD = 5'b00011, OP_SUB = 5'b00100, OP_AND = 5'b00101, OP_OR = 5'b00110;
   localparam logic [4:0] OP_ADDI = 5'b01100, OP_ANDI = 5'b01101, OP_ORI = 5'b01110;
   localparam logic [4:0] OP_BR = 5'b10010, OP_JR = 5'b10100, OP_HALT = 5'b11011;

   localparam logic [24:0] M_PCOUT = 25'h0000001, M_PCIN = 25'h0000002, M_INCPC = 25'h0000004;
   localparam logic [24:0] M_MARIN = 25'h0000008, M_READ = 25'h0000010, M_WRITE = 25'h0000020;
   localparam logic [24:0] M_MDREAD = 25'h0000040, M_MDRIN = 25'h0000080, M_MDROUT = 25'h0000100;
   localparam logic [24:0] M_IRIN = 25'h0000200, M_YIN = 25'h0000400, M_ZLOWIN = 25'h0000800;
   localparam logic [24:0] M_ZLOWOUT = 25'h0001000, M_GRA = 25'h0002000, M_GRB = 25'h0004000;
   localparam logic [24:0] M_GRC = 25'h0008000, M_RIN = 25'h0010000, M_ROUT = 25'h0020000;
   localparam logic [24:0] M_BAOUT = 25'h0040000, M_CSIGN = 25'h0080000, M_CONIN = 25'h0100000;
   localparam logic [24:0] M_ADD = 25'h0200000, M_SUB = 25'h0400000, M_AND = 25'h0800000;
   localparam logic [24:0] M_OR = 25'h1000000;

   logic        clock, clear, CON;
   logic [31:0] IR;
   logic PCout, PCin, IncPC, MARin, Read, Write, MD_read, MDRin, MDRout, IRin, Yin;
   logic Zlowin, Zlowout, Gra, Grb, Grc, Rin, Rout, BAout, Csignout, CONin;
   logic ADD, SUB, AND, OR, Run;
   logic [24:0] dut_vec;

   control_sequencer dut (
      .clock(clock), .clear(clear), .IR(IR), .CON(CON),
      .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .Read(Read),
      .Write(Write), .MD_read(MD_read), .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin),
      .Yin(Yin), .Zlowin(Zlowin), .Zlowout(Zlowout), .Gra(Gra), .Grb(Grb), .Grc(Grc),
      .Rin(Rin), .Rout(Rout), .BAout(BAout), .Csignout(Csignout), .CONin(CONin),
      .ADD(ADD), .SUB(SUB), .AND(AND), .OR(OR), .Run(Run)
   );

   assign dut_vec = {OR, AND, SUB, ADD, CONin, Csignout, BAout, Rout, Rin, Grc, Grb, Gra,
                     Zlowout, Zlowin, Yin, IRin, MDRout, MDRin, MD_read, Write, Read,
                     MARin, IncPC, PCin, PCout};

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [24:0] exp_out;
   logic        exp_run;
   bit          exp_valid = 1'b0;
   logic [24:0] pin_exp;
   bit          pin_valid = 1'b0;
   string       cur_tag = "init";
   int          cur_step = 0;

   logic [24:0] exp_q [$];
   bit          halt_m;
   logic [24:0] pin_tab [0:7];
   bit          pin_en   [0:7];

   logic [4:0] ops [0:11] = '{OP_LD, OP_LDI, OP_ST, OP_ADD, OP_SUB, OP_AND, OP_OR,
                              OP_ADDI, OP_ANDI, OP_ORI, OP_BR, OP_JR};

   // Single compare process: model expectation every cycle plus optional hand-pinned literal.
   always @(negedge clock) begin
      if (exp_valid) begin
         n_checks++;
         if (dut_vec !== exp_out || Run !== exp_run) begin
            n_errors++;
            $display("FAIL %s step %0d: strobes=%h Run=%b, expected strobes=%h Run=%b",
                     cur_tag, cur_step, dut_vec, Run, exp_out, exp_run);
         end
         if (pin_valid) begin
            n_checks++;
            if (dut_vec !== pin_exp) begin
               n_errors++;
               $display("FAIL pin %s step %0d: strobes=%h, expected literal %h",
                        cur_tag, cur_step, dut_vec, pin_exp);
            end
         end
      end
   end

   function automatic logic [24:0] alu_mask(input logic [4:0] op);
      case (op)
         OP_SUB:          return M_SUB;
         OP_AND, OP_ANDI: return M_AND;
         OP_OR, OP_ORI:   return M_OR;
         default:         return M_ADD;
      endcase
   endfunction

   // Micro-step list of one instruction: the three fetch steps, then its execute steps.
   task automatic build_seq(input logic [4:0] op, input logic con);
      logic [24:0] addr_a, addr_b;
      addr_a = M_GRB | M_BAOUT | M_YIN;
      addr_b = M_CSIGN | M_ADD | M_ZLOWIN;
      exp_q.delete();
      halt_m = 1'b0;
      exp_q.push_back(M_PCOUT | M_MARIN | M_INCPC | M_ZLOWIN);
      exp_q.push_back(M_ZLOWOUT | M_PCIN | M_READ | M_MDREAD | M_MDRIN);
      exp_q.push_back(M_MDROUT | M_IRIN);
      case (op)
         OP_LDI: begin
            exp_q.push_back(addr_a); exp_q.push_back(addr_b);
            exp_q.push_back(M_ZLOWOUT | M_GRA | M_RIN);
         end
         OP_LD: begin
            exp_q.push_back(addr_a); exp_q.push_back(addr_b);
            exp_q.push_back(M_ZLOWOUT | M_MARIN);
            exp_q.push_back(M_READ | M_MDREAD | M_MDRIN);
            exp_q.push_back(M_MDROUT | M_GRA | M_RIN);
         end
         OP_ST: begin
            exp_q.push_back(addr_a); exp_q.push_back(addr_b);
            exp_q.push_back(M_ZLOWOUT | M_MARIN);
            exp_q.push_back(M_GRA | M_ROUT | M_MDRIN);
            exp_q.push_back(M_WRITE);
         end
         OP_ADD, OP_SUB, OP_AND, OP_OR: begin
            exp_q.push_back(M_GRB | M_ROUT | M_YIN);
            exp_q.push_back(M_GRC | M_ROUT | alu_mask(op) | M_ZLOWIN);
            exp_q.push_back(M_ZLOWOUT | M_GRA | M_RIN);
         end
         OP_ADDI, OP_ANDI, OP_ORI: begin
            exp_q.push_back(M_GRB | M_ROUT | M_YIN);
            exp_q.push_back(M_CSIGN | alu_mask(op) | M_ZLOWIN);
            exp_q.push_back(M_ZLOWOUT | M_GRA | M_RIN);
         end
         OP_BR: begin
            exp_q.push_back(M_GRA | M_ROUT | M_CONIN);
            exp_q.push_back(M_PCOUT | M_YIN);
            exp_q.push_back(M_CSIGN | M_ADD | M_ZLOWIN);
            exp_q.push_back(con ? (M_ZLOWOUT | M_PCIN) : 25'h0);
         end
         OP_JR:   exp_q.push_back(M_GRA | M_ROUT | M_PCIN);
         OP_HALT: begin exp_q.push_back(25'h0); halt_m = 1'b1; end
         default: exp_q.push_back(25'h0);
      endcase
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic clear_pins();
      for (int k = 0; k < 8; k++) begin
         pin_en[k]  = 1'b0;
         pin_tab[k] = 25'h0;
      end
   endtask

   // Hold clear for two edges, release it, and land in T0 one edge later.
   task automatic do_reset();
      clear = 1'b1; pin_valid = 1'b0;
      exp_out = 25'h0; exp_run = 1'b0; exp_valid = 1'b1;
      cur_tag = "reset"; cur_step = 0;
      tick(); tick();
      clear = 1'b0;
      tick();
   endtask

   // Entered at the start of T0; IR carries the instruction only during T3.
   task automatic run_instr(input string tag, input logic [31:0] ir_word, input logic con, input int abort_at);
      logic [4:0] op;
      op = ir_word[31:27];
      build_seq(op, con);
      cur_tag = tag;
      for (int i = 0; i < exp_q.size(); i++) begin
         cur_step  = i;
         IR        = (i == 3) ? ir_word : $urandom;
         CON       = (op == OP_BR && i == 6) ? con : 1'($urandom);
         exp_out   = exp_q[i];
         exp_run   = 1'b1;
         pin_valid = pin_en[i];
         pin_exp   = pin_tab[i];
         if (i == abort_at) begin
            #2;
            do_reset();
            return;
         end
         tick();
      end
      pin_valid = 1'b0;
      if (halt_m) begin
         for (int j = 0; j < 25; j++) begin
            cur_tag = "halt"; cur_step = j;
            IR = $urandom; CON = 1'($urandom);
            exp_out = 25'h0; exp_run = 1'b0;
            tick();
         end
         do_reset();
      end
   endtask

   initial begin
      clear = 1'b1; IR = 32'h0; CON = 1'b0;
      exp_out = 25'h0; exp_run = 1'b0; pin_exp = 25'h0;
      clear_pins();
      do_reset();

      pin_en[0] = 1'b1; pin_tab[0] = 25'h000080D;
      pin_en[3] = 1'b1; pin_tab[3] = 25'h0044400;
      pin_en[4] = 1'b1; pin_tab[4] = 25'h0280800;
      pin_en[5] = 1'b1; pin_tab[5] = 25'h0013000;
      run_instr("ldi", 32'h0900_0065, 1'b0, -1);
      clear_pins();

      pin_en[6] = 1'b1; pin_tab[6] = 25'h00000D0;
      pin_en[7] = 1'b1; pin_tab[7] = 25'h0012100;
      run_instr("ld", 32'h0000_0055, 1'b0, -1);
      clear_pins();
      pin_en[6] = 1'b1; pin_tab[6] = 25'h0022080;
      pin_en[7] = 1'b1; pin_tab[7] = 25'h0000020;
      run_instr("st", 32'h1000_0090, 1'b0, -1);
      clear_pins();

      pin_en[4] = 1'b1; pin_tab[4] = 25'h0428800;
      run_instr("sub", {OP_SUB, 27'h0123456}, 1'b0, -1);
      clear_pins();
      pin_en[4] = 1'b1; pin_tab[4] = 25'h1080800;
      run_instr("ori", {OP_ORI, 27'h7654321}, 1'b0, -1);
      clear_pins();

      pin_en[6] = 1'b1; pin_tab[6] = 25'h0001002;
      run_instr("br_taken", {OP_BR, 27'h0000010}, 1'b1, -1);
      clear_pins();
      pin_en[6] = 1'b1; pin_tab[6] = 25'h0000000;
      run_instr("br_not", {OP_BR, 27'h0000010}, 1'b0, -1);
      clear_pins();

      pin_en[3] = 1'b1; pin_tab[3] = 25'h0000000;
      run_instr("undef", {5'b11111, 27'h0}, 1'b0, -1);
      clear_pins();

      run_instr("add_abort", {OP_ADD, 27'h0}, 1'b0, 4);
      run_instr("after_abort", {OP_JR, 27'h0}, 1'b0, -1);
      run_instr("halt", {OP_HALT, 27'h0}, 1'b0, -1);

      for (int n = 0; n < 250; n++) begin
         logic [4:0] op;
         int         sel;
         sel = $urandom_range(0, 19);
         if (sel == 0)      op = 5'($urandom);
         else if (sel == 1) op = OP_HALT;
         else               op = ops[$urandom_range(0, 11)];
         run_instr("rand", {op, 27'($urandom)}, 1'($urandom),
                   ($urandom_range(0, 14) == 0) ? $urandom_range(0, 7) : -1);
      end

      exp_valid = 1'b0;
      @(negedge clock);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Hardwired Moore control unit that drives the single-bus DataPath.
- Steps through fetch (T0–T2), then the instruction-specific execute steps (T3–T7) for each opcode in IR[31:27].
- Asserts the register-select, bus-drive and load strobes each step needs. Today the testbench sets these strobes by hand.
- Sits beside DataPath: takes in IR and the CON flip-flop output, and drives every control input of DataPath.

Parameters:
- OP_LD, 5'b00000, load: Ra <= M[Rb + C]
- OP_LDI, 5'b00001, load immediate: Ra <= Rb + C
- OP_ST, 5'b00010, store: M[Rb + C] <= Ra
- OP_ADD / OP_SUB / OP_AND / OP_OR, 5'b00011 / 00100 / 00101 / 00110, register ALU ops: Ra <= Rb op Rc
- OP_ADDI / OP_ANDI / OP_ORI, 5'b01100 / 01101 / 01110, immediate ALU ops: Ra <= Rb op C
- OP_BR, 5'b10010, conditional branch: PC <= PC + C when CON = 1
- OP_JR, 5'b10100, jump register: PC <= Ra
- OP_HALT, 5'b11011, stop execution

Ports:
- clock  input  1  system clock; every state advances on the rising edge
- clear  input  1  asynchronous, active-high reset
- IR  input  32  instruction register contents; opcode is IR[31:27]
- CON  input  1  branch condition from the CON flip-flop
- PCout, PCin, IncPC  output  1 each  PC bus drive / PC load / PC increment
- MARin, Read, Write, MD_read  output  1 each  MAR load / memory read / memory write / MDR source select (1 = memory, 0 = bus)
- MDRin, MDRout, IRin, Yin  output  1 each  register load/drive strobes
- Zlowin, Zlowout  output  1 each  Z-low register load / drive
- Gra, Grb, Grc, Rin, Rout, BAout  output  1 each  register-file select and load/drive strobes
- Csignout, CONin  output  1 each  sign-extended C onto bus / CON flip-flop load
- ADD, SUB, AND, OR  output  1 each  ALU operation select
- Run  output  1  high while executing; low in RESET and HALT

Behaviour:
- States: RESET, T0, T1, T2, T3..T7, HALT. Exactly one state per clock.
- Outputs are decoded combinationally from the state and the latched opcode only. They are stable for the whole cycle.
- The only exception is CON, which is used in BR T6.
- clear = 1 (asynchronous):
  - state goes to RESET;
  - every output goes to 0, including Run;
  - the opcode latch is cleared;
  - this takes effect immediately, including mid-instruction.
- RESET -> T0 on the first rising edge after clear is released.
- Fetch:
  - T0: PCout, MARin, IncPC, Zlowin.
  - T1: Zlowout, PCin, Read, MD_read, MDRin.
  - T2: MDRout, IRin. The opcode is captured from IR on the edge leaving T3 (IR is valid in T3).
- T3 onward uses the opcode from IR during T3 and the latched copy afterwards.
- LDI:
  - T3: Grb, BAout, Yin.
  - T4: Csignout, ADD, Zlowin.
  - T5: Zlowout, Gra, Rin. Then -> T0.
- LD:
  - T3–T4: as LDI.
  - T5: Zlowout, MARin.
  - T6: Read, MD_read, MDRin.
  - T7: MDRout, Gra, Rin. Then -> T0.
- ST:
  - T3–T5: as LD.
  - T6: Gra, Rout, MDRin (MD_read = 0).
  - T7: Write. Then -> T0.
- Register ALU ops:
  - T3: Grb, Rout, Yin.
  - T4: Grc, Rout, op strobe, Zlowin.
  - T5: Zlowout, Gra, Rin. Then -> T0.
- Immediate ALU ops:
  - T3: Grb, Rout, Yin.
  - T4: Csignout, op strobe, Zlowin.
  - T5: Zlowout, Gra, Rin. Then -> T0.
- BR:
  - T3: Gra, Rout, CONin.
  - T4: PCout, Yin.
  - T5: Csignout, ADD, Zlowin.
  - T6: Zlowout and PCin only if CON = 1; otherwise no strobes. Then -> T0.
- JR: T3: Gra, Rout, PCin. Then -> T0.
- HALT: T3 -> HALT. HALT is held with Run = 0 and all strobes 0. Only clear exits it.
- Undefined opcode: treated as NOP. T3 asserts no strobes, then -> T0.
- Bus exclusivity: at most one bus driver is asserted in any state. The bus drivers are PCout, Zlowout, MDRout, Rout, BAout and Csignout.
- At most one ALU op strobe is asserted in any state.

Test Plan:
- Reset: assert clear mid-T4 of an ADD -> all outputs 0 immediately, state RESET; after release, T0 follows on the next edge with PCout = MARin = IncPC = Zlowin = 1.
- LDI: IR = 0x0900_0065 -> T3 {Grb, BAout, Yin}, T4 {Csignout, ADD, Zlowin}, T5 {Zlowout, Gra, Rin}, then T0. Total 6 cycles.
- LD then ST: IR = 0x0000_0055 gives 8 cycles with Read and MD_read in T6 and Gra, Rin in T7. IR = 0x1000_0090 gives Write only in T7 and MD_read = 0 in T6.
- SUB and ORI: SUB asserts Grc, Rout, SUB in T4. ORI asserts Csignout, OR in T4. Neither asserts any other ALU strobe.
- BR: CON = 1 -> PCin and Zlowout in T6. CON = 0 -> no strobes in T6. Both return to T0.
- HALT / undefined: opcode 11011 -> Run falls after T3 and stays 0 for 20+ cycles until clear. Opcode 11111 -> no strobes in T3, then back to T0.
